sram_bist_master: RTL

Memory-interface initiator that drives the picorv32-style native memory bus (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata) into the SRAM responder for built-in self-test. On start it writes a seed-derived pattern to every word of a configured window, reads it back and compares each word against the expected value. It reports pass/fail, an error count and the first failing address. It replaces the CPU as bus initiator while in test mode.

---
 rtl/sram_bist_master.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sram_bist_master.sv
// sram_bist_master: built-in self-test initiator for the native memory bus.
// On start it writes seed+i to every word of the window at BASE_ADDR, then
// reads each word back and compares it. It reports pass/fail, a saturating
// error count and the address of the first mismatch.
//
// Optional feature macro: SRAM_BIST_INVERT_EN. When defined, a second write
// and read pass with ~(seed+i) follows the first, and errors from both passes
// accumulate into one result.
//
// Parameters : ADDR_WORDS (words tested, >=1), BASE_ADDR (byte address of word 0)
// Ports      : clk, rstn               clock, async active-low reset
//              start, seed             run request pulse and pattern seed
//              mem_valid .. mem_wstrb  bus request (initiator side)
//              mem_rdata, mem_ready    bus response
//              busy, done, pass        run status
//              err_count, err_addr     mismatch count and first failing address
module sram_bist_master #(
   parameter int unsigned ADDR_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic [31:0] seed,
   output logic        mem_valid,
   output logic        mem_instr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_count,
   output logic [31:0] err_addr
);

   localparam int unsigned      IDX_W    = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ADDR_WORDS - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_REQ,
      S_WR_GAP,
      S_RD_REQ,
      S_RD_GAP,
      S_DONE
`ifdef SRAM_BIST_INVERT_EN
      , S_INV_WR_REQ
      , S_INV_WR_GAP
      , S_INV_RD_REQ
      , S_INV_RD_GAP
`endif
   } state_t;

   state_t           r_state;
   logic [IDX_W-1:0] r_idx;
   logic [31:0]      r_seed;
   logic [31:0]      r_addr;
   logic [31:0]      r_wdata;
   logic [3:0]       r_wstrb;
   logic             r_valid;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [15:0]      r_err_count;
   logic [31:0]      r_err_addr;

   logic [IDX_W-1:0] w_idx_next;
   logic             w_last;
   logic             w_accept;
   logic             w_rd_req;
   logic [31:0]      w_next_addr;
   logic [31:0]      w_next_word;
   logic [31:0]      w_exp;
   logic             w_err_hit;

   assign w_idx_next  = r_idx + IDX_W'(1);
   assign w_last      = (r_idx == LAST_IDX);
   assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_next_addr = BASE_ADDR + (32'(w_idx_next) << 2);
   assign w_next_word = r_seed + 32'(w_idx_next);

   // Expected read word for the current index; complemented in the inverted pass
`ifdef SRAM_BIST_INVERT_EN
   assign w_rd_req = (r_state == S_RD_REQ) || (r_state == S_INV_RD_REQ);
   assign w_exp    = (r_state == S_INV_RD_REQ) ? ~(r_seed + 32'(r_idx)) : (r_seed + 32'(r_idx));
`else
   assign w_rd_req = (r_state == S_RD_REQ);
   assign w_exp    = r_seed + 32'(r_idx);
`endif

   assign w_err_hit = w_rd_req && mem_ready && (mem_rdata != w_exp);

   // Sequencer: one request per word, each followed by a single idle gap cycle
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_seed  <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_seed  <= seed;
                  r_idx   <= '0;
                  r_addr  <= BASE_ADDR;
                  r_wdata <= seed;
                  r_wstrb <= 4'hF;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_pass  <= 1'b0;
                  r_state <= S_WR_REQ;
               end
            end
            S_WR_REQ: begin
               if (mem_ready) begin
                  r_valid <= 1'b0;
                  r_state <= S_WR_GAP;
               end
            end
            S_WR_GAP: begin
               r_valid <= 1'b1;
               if (w_last) begin
                  r_idx   <= '0;
                  r_addr  <= BASE_ADDR;
                  r_wdata <= '0;
                  r_wstrb <= 4'h0;
                  r_state <= S_RD_REQ;
               end else begin
                  r_idx   <= w_idx_next;
                  r_addr  <= w_next_addr;
                  r_wdata <= w_next_word;
                  r_state <= S_WR_REQ;
               end
            end
            S_RD_REQ: begin
               if (mem_ready) begin
                  r_valid <= 1'b0;
                  r_state <= S_RD_GAP;
               end
            end
            S_RD_GAP: begin
               if (w_last) begin
`ifdef SRAM_BIST_INVERT_EN
                  r_idx   <= '0;
                  r_addr  <= BASE_ADDR;
                  r_wdata <= ~r_seed;
                  r_wstrb <= 4'hF;
                  r_valid <= 1'b1;
                  r_state <= S_INV_WR_REQ;
`else
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (r_err_count == 16'h0000);
                  r_state <= S_DONE;
`endif
               end else begin
                  r_idx   <= w_idx_next;
                  r_addr  <= w_next_addr;
                  r_valid <= 1'b1;
                  r_state <= S_RD_REQ;
               end
            end
`ifdef SRAM_BIST_INVERT_EN
            S_INV_WR_REQ: begin
               if (mem_ready) begin
                  r_valid <= 1'b0;
                  r_state <= S_INV_WR_GAP;
               end
            end
            S_INV_WR_GAP: begin
               r_valid <= 1'b1;
               if (w_last) begin
                  r_idx   <= '0;
                  r_addr  <= BASE_ADDR;
                  r_wdata <= '0;
                  r_wstrb <= 4'h0;
                  r_state <= S_INV_RD_REQ;
               end else begin
                  r_idx   <= w_idx_next;
                  r_addr  <= w_next_addr;
                  r_wdata <= ~w_next_word;
                  r_state <= S_INV_WR_REQ;
               end
            end
            S_INV_RD_REQ: begin
               if (mem_ready) begin
                  r_valid <= 1'b0;
                  r_state <= S_INV_RD_GAP;
               end
            end
            S_INV_RD_GAP: begin
               if (w_last) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (r_err_count == 16'h0000);
                  r_state <= S_DONE;
               end else begin
                  r_idx   <= w_idx_next;
                  r_addr  <= w_next_addr;
                  r_valid <= 1'b1;
                  r_state <= S_INV_RD_REQ;
               end
            end
`endif
            default: begin
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Error accounting: cleared on an accepted start, first mismatch address kept
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_err_count <= '0;
         r_err_addr  <= '0;
      end else if (w_accept) begin
         r_err_count <= '0;
         r_err_addr  <= '0;
      end else if (w_err_hit) begin
         if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
         if (r_err_count == 16'h0000) r_err_addr  <= r_addr;
      end
   end

   assign mem_valid = r_valid;
   assign mem_instr = 1'b0;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_wstrb = r_wstrb;
   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign err_count = r_err_count;
   assign err_addr  = r_err_addr;

endmodule
